// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    localparam int unsigned MAX_N   = 8;
    localparam int unsigned FIFO_DW = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Binary index of the set bit; 0 for an all-zero vector.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < int'(MAX_N); i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester at or after rr_ptr, modulo N.
module rr_picker #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   rr_ptr,
    output logic         valid,
    output logic [2:0]   idx
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;

    assign w_dbl = {req, req} >> rr_ptr;
    assign w_rot = w_dbl[N-1:0];

    always_comb begin
        int unsigned s;
        valid = 1'b0;
        idx   = 3'd0;
        s     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            if (w_rot[k] && !valid) begin
                valid = 1'b1;
                s     = 32'(rr_ptr) + k;
                if (s >= N) s = s - N;
                idx   = 3'(s);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N producers in bounded bursts.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N*DW-1:0]   req_data,
    input  logic [N-1:0]      req_last,
    output logic [N-1:0]      ack,
    output logic [N-1:0]      grant,
    output logic [2:0]        grant_id,
    output logic              fifo_wr_en,
    output logic [DW-1:0]     fifo_wr_data,
    input  logic              fifo_full,
    input  logic              fifo_almostfull
);

    arb_state_t   r_state, w_nxt_state;
    logic [N-1:0] r_grant, w_nxt_grant;
    logic [2:0]   r_rr_ptr, w_nxt_rr_ptr;
    logic [3:0]   r_beat_cnt, w_nxt_beat_cnt;

    logic          w_pick_valid;
    logic [2:0]    w_pick_idx;
    logic [2:0]    w_owner;
    logic          w_req_own;
    logic          w_last_own;
    logic          w_beat;
    logic [DW-1:0] w_own_data;
    logic [3:0]    w_cnt_inc;

    rr_picker #(.N(N)) u_rr_picker (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_pick_valid),
        .idx    (w_pick_idx)
    );

    assign w_owner    = onehot_to_idx(MAX_N'(r_grant));
    assign w_req_own  = |(req & r_grant);
    assign w_last_own = |(req_last & r_grant);
    assign w_cnt_inc  = r_beat_cnt + 4'd1;

    always_comb begin
        w_own_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_grant[i]) w_own_data = req_data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= 3'd0;
            r_beat_cnt <= 4'd0;
        end else begin
            r_state    <= w_nxt_state;
            r_grant    <= w_nxt_grant;
            r_rr_ptr   <= w_nxt_rr_ptr;
            r_beat_cnt <= w_nxt_beat_cnt;
        end
    end

    // Burst closes on abandon, on a final beat, or on reaching the beat cap.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_grant    = r_grant;
        w_nxt_rr_ptr   = r_rr_ptr;
        w_nxt_beat_cnt = r_beat_cnt;
        w_beat         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_valid && !fifo_almostfull) begin
                    w_nxt_grant    = {{(N-1){1'b0}}, 1'b1} << w_pick_idx;
                    w_nxt_beat_cnt = 4'd0;
                    w_nxt_state    = BURST;
                end
            end
            BURST: begin
                w_beat = w_req_own && !fifo_full && !rst;
                if (!w_req_own || (w_beat && (w_last_own || w_cnt_inc == 4'(MAX_BURST)))) begin
                    w_nxt_state    = IDLE;
                    w_nxt_grant    = '0;
                    w_nxt_beat_cnt = 4'd0;
                    w_nxt_rr_ptr   = (w_owner == 3'(N-1)) ? 3'd0 : w_owner + 3'd1;
                end else if (w_beat) begin
                    w_nxt_beat_cnt = w_cnt_inc;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    assign grant        = r_grant;
    assign grant_id     = w_owner;
    assign fifo_wr_en   = w_beat;
    assign ack          = w_beat ? r_grant : '0;
    assign fifo_wr_data = w_beat ? w_own_data : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter against a transaction-level model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    ack;
    logic [N-1:0]    grant;
    logic [2:0]      grant_id;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic            fifo_full;
    logic            fifo_almostfull;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_data        (req_data),
        .req_last        (req_last),
        .ack             (ack),
        .grant           (grant),
        .grant_id        (grant_id),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_wr_data    (fifo_wr_data),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner index (-1 when idle), next priority slot, beats taken this burst.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int cyc     = 0;

    int wlog[$];
    int olog[$];
    int tlog[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] rq, input logic [N*DW-1:0] dat,
                        input logic [N-1:0] lst, input logic fl, input logic af,
                        input logic r);
        logic          beat;
        logic [N-1:0]  egrant;
        logic [DW-1:0] edata;
        logic          any;
        @(negedge clk);
        req = rq; req_data = dat; req_last = lst;
        fifo_full = fl; fifo_almostfull = af; rst = r;
        #1;
        egrant = '0;
        edata  = '0;
        beat   = 1'b0;
        if (m_owner >= 0) begin
            egrant[m_owner] = 1'b1;
            beat = rq[m_owner] && !fl && !r;
            if (beat) edata = dat[m_owner*DW +: DW];
        end
        check("grant",    32'(grant),        32'(egrant));
        check("grant_id", 32'(grant_id),     (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("ack",      32'(ack),          beat ? 32'(egrant) : 32'd0);
        check("wr_en",    32'(fifo_wr_en),   32'(beat));
        check("wr_data",  32'(fifo_wr_data), 32'(edata));
        if (fifo_wr_en) begin
            wlog.push_back(int'(fifo_wr_data));
            tlog.push_back(cyc);
            for (int i = 0; i < N; i++) if (ack[i]) olog.push_back(i);
        end
        @(posedge clk);
        cyc++;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            any = 1'b0;
            if (!af) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (rq[c] && !any) begin
                        any = 1'b1; m_owner = c; m_cnt = 0;
                    end
                end
            end
        end else if (!rq[m_owner]) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1;
        end else if (beat) begin
            m_cnt++;
            if (lst[m_owner] || m_cnt == MB) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1;
            end
        end
    endtask

    task automatic clear_logs();
        wlog.delete(); olog.delete(); tlog.delete();
    endtask

    initial begin
        logic [N*DW-1:0] d;
        rst = 1'b1; req = '0; req_data = '0; req_last = '0;
        fifo_full = 1'b0; fifo_almostfull = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then a single requester capped at MB beats twice.
        step('0, '0, '0, 1'b0, 1'b0, 1'b0);
        clear_logs();
        for (int s = 0; s < 10; s++) begin
            d = '0;
            d[2*DW +: DW] = DW'(8'hA0 + wlog.size());
            step(4'b0100, d, '0, 1'b0, 1'b0, 1'b0);
        end
        check("cap_count", 32'(wlog.size()), 32'd8);
        for (int i = 0; i < 8 && i < wlog.size(); i++)
            check("cap_data", 32'(wlog[i]), 32'(8'hA0 + i));
        if (tlog.size() == 8) check("cap_gap", 32'(tlog[4] - tlog[3]), 32'd2);
        step('0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Round-robin fairness with single-beat bursts.
        step('0, '0, '0, 1'b0, 1'b0, 1'b1);
        clear_logs();
        for (int s = 0; s < 10; s++) step(4'b1111, 32'h44332211, 4'b1111, 1'b0, 1'b0, 1'b0);
        check("rr_count", 32'(olog.size()), 32'd5);
        for (int i = 0; i < 5 && i < olog.size(); i++) begin
            check("rr_order", 32'(olog[i]), 32'(i % N));
            if (i > 0) check("rr_spacing", 32'(tlog[i] - tlog[i-1]), 32'd2);
        end

        // Full stall mid-burst for owner 1.
        step('0, '0, '0, 1'b0, 1'b0, 1'b1);
        clear_logs();
        step(4'b0010, 32'h0000_5500, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) step(4'b0010, 32'h0000_5600, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(4'b0010, 32'h0000_5700, '0, 1'b1, 1'b0, 1'b0);
        check("stall_grant", 32'(grant), 32'b0010);
        repeat (3) step(4'b0010, 32'h0000_5800, '0, 1'b0, 1'b0, 1'b0);
        check("stall_total", 32'(wlog.size()), 32'd4);
        step('0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Almostfull holds off a new burst.
        repeat (5) step(4'b0001, 32'h0000_0077, '0, 1'b0, 1'b1, 1'b0);
        step(4'b0001, 32'h0000_0077, 4'b0001, 1'b0, 1'b0, 1'b0);
        step(4'b0001, 32'h0000_0077, 4'b0001, 1'b0, 1'b0, 1'b0);
        step('0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Abandon by owner 3 and wrap of priority to 0.
        step('0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(4'b1000, 32'h9900_0000, '0, 1'b0, 1'b0, 1'b0);
        step(4'b1001, 32'h9900_0011, '0, 1'b0, 1'b0, 1'b0);
        step(4'b0001, 32'h0000_0011, '0, 1'b0, 1'b0, 1'b0);
        step(4'b0001, 32'h0000_0011, '0, 1'b0, 1'b0, 1'b0);
        check("wrap_id", 32'(grant_id), 32'd0);
        step(4'b0001, 32'h0000_0011, 4'b0001, 1'b0, 1'b0, 1'b0);

        // Reset during owner 2's second beat.
        step('0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(4'b0100, 32'h00BB_0000, '0, 1'b0, 1'b0, 1'b0);
        step(4'b0100, 32'h00BC_0000, '0, 1'b0, 1'b0, 1'b0);
        step(4'b0100, 32'h00BD_0000, '0, 1'b0, 1'b0, 1'b1);
        step(4'b0110, 32'h00BE_CC00, '0, 1'b0, 1'b0, 1'b0);
        step(4'b0110, 32'h00BE_CC00, '0, 1'b0, 1'b0, 1'b0);
        check("rst_regrant", 32'(grant), 32'b0010);

        // Random traffic.
        for (int s = 0; s < 3000; s++) begin
            logic [N-1:0] lst;
            for (int i = 0; i < N; i++) lst[i] = ($urandom_range(3) == 0);
            step(N'($urandom), (N*DW)'($urandom), lst,
                 $urandom_range(3) == 0, $urandom_range(2) == 0,
                 $urandom_range(199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
